// File: rtl/act_sched_pkg.sv
// Shared types and helpers for the ACT throttle scheduler.
package act_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int ROW_W_DEF = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first eligible index at or after rr_ptr, wrapping.
module rr_pick
    import act_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] j;

    // Scan N_REQ positions starting at rr_ptr; rr_ptr < N_REQ so one wrap suffices.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ))
                sum = sum - (IW+1)'(N_REQ);
            j = sum[IW-1:0];
            if (!found && eligible[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/act_throttle_sched.sv
// Row-activation scheduler: round-robin over requesters, checks each candidate
// row against the history buffer, defers blacklisted+recent rows with a
// per-requester back-off, and records every issued ACT in the buffer.
module act_throttle_sched
    import act_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ROW_W          = ROW_W_DEF,
    parameter int BACKOFF_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ROW_W-1:0]   req_row_addr,
    input  logic [N_REQ-1:0]         req_blacklisted,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     act_valid,
    input  logic                     act_ready,
    output logic [ROW_W-1:0]         act_row_addr,
    output logic [$clog2(N_REQ)-1:0] act_req_id,
    output logic [ROW_W-1:0]         hb_row_addr,
    output logic                     hb_insert_valid,
    input  logic                     hb_match,
    output logic [CNT_W-1:0]         blocked_cnt,
    output logic                     busy
);

    localparam int IW = id_w(N_REQ);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    rr_ptr, cand_id, next_ptr, pick_idx;
    logic [ROW_W-1:0] cand_addr;
    logic             cand_bl;
    logic             pick_found, blocked, handshake;
    logic [N_REQ-1:0] eligible;
    logic [BW-1:0]    backoff [N_REQ];
    logic [ROW_W-1:0] rows    [N_REQ];

    // Unpack row addresses and derive per-requester eligibility.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rows[i]     = req_row_addr[i*ROW_W +: ROW_W];
            eligible[i] = req_valid[i] && (backoff[i] == '0);
        end
    end

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign blocked   = (state == QUERY) && hb_match && cand_bl;
    // A reset cycle abandons the candidate, so no handshake can complete in it.
    assign handshake = (state == ISSUE) && act_ready && !rst;
    assign next_ptr  = (cand_id == IW'(N_REQ - 1)) ? '0 : cand_id + 1'b1;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and command/buffer outputs.
    always_comb begin
        state_nxt       = state;
        act_valid       = 1'b0;
        req_ready       = '0;
        hb_insert_valid = 1'b0;
        hb_row_addr     = '0;
        busy            = (state != IDLE) && !rst;
        act_row_addr    = cand_addr;
        act_req_id      = cand_id;
        case (state)
            IDLE:  if (pick_found) state_nxt = QUERY;
            QUERY: begin
                hb_row_addr = cand_addr;
                state_nxt   = blocked ? IDLE : ISSUE;
            end
            ISSUE: begin
                hb_row_addr = cand_addr;
                act_valid   = !rst;
                if (handshake) begin
                    req_ready[cand_id] = 1'b1;
                    hb_insert_valid    = 1'b1;
                end
                if (act_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Candidate latch, round-robin pointer and blocked-ACT counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cand_id     <= '0;
            cand_addr   <= '0;
            cand_bl     <= 1'b0;
            blocked_cnt <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                cand_id   <= pick_idx;
                cand_addr <= rows[pick_idx];
                cand_bl   <= req_blacklisted[pick_idx];
            end
            if (blocked) begin
                rr_ptr <= next_ptr;
                if (blocked_cnt != '1)
                    blocked_cnt <= blocked_cnt + 1'b1;
            end
            if (state == ISSUE && act_ready)
                rr_ptr <= next_ptr;
        end
    end

    // Back-off counters: load on a block, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) backoff[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (blocked && cand_id == IW'(i))
                    backoff[i] <= BW'(BACKOFF_CYCLES);
                else if (backoff[i] != '0)
                    backoff[i] <= backoff[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_act_throttle_sched.sv
// Directed bench for act_throttle_sched (N_REQ=4, BACKOFF_CYCLES=4).
module tb_act_throttle_sched;

    localparam int N  = 4;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*RW-1:0] req_row_addr;
    logic [N-1:0]  req_blacklisted;
    logic [N-1:0]  req_ready;
    logic          act_valid;
    logic          act_ready;
    logic [RW-1:0] act_row_addr;
    logic [1:0]    act_req_id;
    logic [RW-1:0] hb_row_addr;
    logic          hb_insert_valid;
    logic          hb_match;
    logic [15:0]   blocked_cnt;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    act_throttle_sched #(.N_REQ(N), .ROW_W(RW), .BACKOFF_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_row_addr(req_row_addr),
        .req_blacklisted(req_blacklisted), .req_ready(req_ready), .act_valid(act_valid),
        .act_ready(act_ready), .act_row_addr(act_row_addr), .act_req_id(act_req_id),
        .hb_row_addr(hb_row_addr), .hb_insert_valid(hb_insert_valid), .hb_match(hb_match),
        .blocked_cnt(blocked_cnt), .busy(busy)
    );

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_row_addr = '0; req_blacklisted = '0;
        act_ready = 1'b0; hb_match = 1'b0;
        tick(); tick();
        checks++; if (act_valid !== 1'b0) begin failures++; $display("FAIL reset_act_valid got=%0b exp=0", act_valid); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        checks++; if (hb_insert_valid !== 1'b0) begin failures++; $display("FAIL reset_insert got=%0b exp=0", hb_insert_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (blocked_cnt !== 16'd0) begin failures++; $display("FAIL reset_blocked_cnt got=%0d exp=0", blocked_cnt); end
        checks++; if (act_row_addr !== 16'd0 || act_req_id !== 2'd0) begin failures++; $display("FAIL reset_act_fields got=%0h/%0d exp=0/0", act_row_addr, act_req_id); end
        checks++; if (hb_row_addr !== 16'd0) begin failures++; $display("FAIL reset_hb_addr got=%0h exp=0", hb_row_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0010; req_row_addr[1*RW +: RW] = 16'h0123; req_blacklisted = '0;
        act_ready = 1'b1; hb_match = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
        tick();
        checks++; if (busy !== 1'b1 || act_valid !== 1'b0) begin failures++; $display("FAIL single_query got busy=%0b av=%0b exp 1/0", busy, act_valid); end
        checks++; if (hb_row_addr !== 16'h0123) begin failures++; $display("FAIL single_hb_addr got=%0h exp=0123", hb_row_addr); end
        tick();
        checks++; if (act_valid !== 1'b1) begin failures++; $display("FAIL single_act_valid got=%0b exp=1", act_valid); end
        checks++; if (act_row_addr !== 16'h0123 || act_req_id !== 2'd1) begin failures++; $display("FAIL single_act_fields got=%0h/%0d exp=0123/1", act_row_addr, act_req_id); end
        checks++; if (req_ready !== 4'b0010 || hb_insert_valid !== 1'b1) begin failures++; $display("FAIL single_pulses got rr=%0b ins=%0b exp 0010/1", req_ready, hb_insert_valid); end
        req_valid = '0;
        tick();
        checks++; if (busy !== 1'b0 || act_valid !== 1'b0) begin failures++; $display("FAIL single_done got busy=%0b av=%0b exp 0/0", busy, act_valid); end
    endtask

    task automatic test_blocked();
        // rr_ptr is 2 after the previous ACT.
        req_valid = 4'b0100; req_row_addr[2*RW +: RW] = 16'h0BAD; req_blacklisted = 4'b0100;
        hb_match = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || act_valid !== 1'b0) begin failures++; $display("FAIL blk_query got busy=%0b av=%0b exp 1/0", busy, act_valid); end
        tick();
        checks++; if (busy !== 1'b0 || act_valid !== 1'b0) begin failures++; $display("FAIL blk_deferred got busy=%0b av=%0b exp 0/0", busy, act_valid); end
        checks++; if (blocked_cnt !== 16'd1) begin failures++; $display("FAIL blk_cnt1 got=%0d exp=1", blocked_cnt); end
        for (int c = 3; c <= 6; c++) begin
            tick();
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL blk_backoff_c%0d busy got=%0b exp=0", c, busy); end
        end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL blk_reselect busy got=%0b exp=1", busy); end
        tick();
        checks++; if (blocked_cnt !== 16'd2 || act_valid !== 1'b0) begin failures++; $display("FAIL blk_cnt2 got=%0d av=%0b exp 2/0", blocked_cnt, act_valid); end
        req_valid = '0; req_blacklisted = '0; hb_match = 1'b0;
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_match_not_bl();
        // rr_ptr is 3 after the last block.
        req_valid = 4'b1000; req_row_addr[3*RW +: RW] = 16'h0777; req_blacklisted = '0;
        hb_match = 1'b1; act_ready = 1'b1;
        tick(); tick();
        checks++; if (act_valid !== 1'b1 || act_req_id !== 2'd3 || act_row_addr !== 16'h0777) begin failures++; $display("FAIL mnb_issue got av=%0b id=%0d row=%0h exp 1/3/0777", act_valid, act_req_id, act_row_addr); end
        checks++; if (blocked_cnt !== 16'd2) begin failures++; $display("FAIL mnb_cnt got=%0d exp=2", blocked_cnt); end
        req_valid = '0; hb_match = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) req_row_addr[i*RW +: RW] = 16'h1000 + 16'(i);
        req_valid = 4'b1111; req_blacklisted = '0; hb_match = 1'b0; act_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            logic       ev;
            logic [1:0] eid;
            tick();
            ev  = (c % 3 == 2);
            eid = 2'(((c - 2) / 3) % 4);
            checks++;
            if (act_valid !== ev) begin failures++; $display("FAIL rr_valid_c%0d got=%0b exp=%0b", c, act_valid, ev); end
            else if (ev && (act_req_id !== eid || act_row_addr !== 16'h1000 + 16'(eid) || req_ready !== 4'(1 << eid))) begin
                failures++; $display("FAIL rr_id_c%0d got id=%0d row=%0h rr=%0b exp id=%0d", c, act_req_id, act_row_addr, req_ready, eid);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1.
        req_valid = 4'b0010; req_row_addr[1*RW +: RW] = 16'h0ABC; act_ready = 1'b0;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (act_valid !== 1'b1 || act_row_addr !== 16'h0ABC || req_ready !== 4'b0 || hb_insert_valid !== 1'b0) begin
                failures++; $display("FAIL bp_hold_c%0d got av=%0b row=%0h rr=%0b ins=%0b", c, act_valid, act_row_addr, req_ready, hb_insert_valid);
            end
            tick();
        end
        act_ready = 1'b1; #1;
        checks++; if (req_ready !== 4'b0010 || hb_insert_valid !== 1'b1 || act_valid !== 1'b1) begin failures++; $display("FAIL bp_release got rr=%0b ins=%0b av=%0b exp 0010/1/1", req_ready, hb_insert_valid, act_valid); end
        req_valid = '0;
        tick();
        checks++; if (act_valid !== 1'b0 || req_ready !== 4'b0 || hb_insert_valid !== 1'b0) begin failures++; $display("FAIL bp_after got av=%0b rr=%0b ins=%0b exp 0", act_valid, req_ready, hb_insert_valid); end
    endtask

    task automatic test_reset_mid_issue();
        req_valid = 4'b0001; req_row_addr[0 +: RW] = 16'h0055; act_ready = 1'b1;
        tick(); tick();
        checks++; if (act_valid !== 1'b1) begin failures++; $display("FAIL rmi_issue got av=%0b exp=1", act_valid); end
        rst = 1'b1; #1;
        checks++; if (req_ready !== 4'b0 || hb_insert_valid !== 1'b0) begin failures++; $display("FAIL rmi_no_pulse got rr=%0b ins=%0b exp 0/0", req_ready, hb_insert_valid); end
        tick();
        rst = 1'b0; req_valid = '0; #1;
        checks++; if (act_valid !== 1'b0 || busy !== 1'b0 || blocked_cnt !== 16'd0) begin failures++; $display("FAIL rmi_after got av=%0b busy=%0b cnt=%0d exp 0/0/0", act_valid, busy, blocked_cnt); end
        tick();
        checks++; if (busy !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL rmi_idle got busy=%0b rr=%0b exp 0/0", busy, req_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_blocked();
        test_match_not_bl();
        test_round_robin();
        test_backpressure();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
